regfile_2r1w: RTL and testbench

- Parametrised register bank: the multi-entry successor of the single 32-bit enable/reset register used across the processor.
- Provides DEPTH entries of WIDTH bits, one write port and two independent read ports.
- Adds per-byte write masking, an optional hardwired-zero entry 0, write-to-read bypass and an optional registered-read mode.
- Sits between decode (read addresses) and writeback (write port) in the 32-bit datapath.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_2r1w_if.sv | 27 ++
 rtl/regfile_rdport.sv | 57 +++++
 rtl/regfile_2r1w.sv | 61 ++++++
 tb/tb_regfile_2r1w.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register bank: default datapath sizes and the
// byte-lane merge used by both the write logic and the read bypass.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;

    // Merge one byte lane: take the new byte when its enable is set, else keep the old one.
    function automatic logic [7:0] lane_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// Write port plus two read ports of the register bank, bundled for decode/writeback.
interface regfile_2r1w_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
);
    logic               we;
    logic [AW-1:0]      waddr;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH/8-1:0] wbe;
    logic [AW-1:0]      raddr_a;
    logic [AW-1:0]      raddr_b;
    logic [WIDTH-1:0]   rdata_a;
    logic [WIDTH-1:0]   rdata_b;

    modport master (
        output we, waddr, wdata, wbe, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we, waddr, wdata, wbe, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );
endinterface

// File: rtl/regfile_rdport.sv
// One read port: entry select, hardwired-zero check, write bypass and the
// optional output register (captured on the falling edge like the bank).
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_R0  = 1'b1,
    parameter bit REG_READ = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      raddr,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [WIDTH-1:0]   mem [DEPTH],
    output logic [WIDTH-1:0]   rdata
);
    logic [WIDTH-1:0] stored;
    logic             bypass_hit;
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Select the entry, overlay a same-cycle write when bypassing, then force entry 0 to zero.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stored     = mem[raddr];
        rdata_d    = stored;
        // A write in a reset cycle is dropped, so it must not be forwarded either.
        bypass_hit = BYPASS && we && !rst && (waddr == raddr);
        if (bypass_hit) begin
            for (int i = 0; i < WIDTH / 8; i++) begin
                rdata_d[8*i +: 8] = lane_merge(stored[8*i +: 8], wdata[8*i +: 8], wbe[i]);
            end
        end
        if (ZERO_R0 && (raddr == '0)) begin
            rdata_d = '0;
        end
    end

    // Optional registered read; unused (and trimmed) when REG_READ is 0.
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(negedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = REG_READ ? rdata_q : rdata_d;

endmodule

// File: rtl/regfile_2r1w.sv
// Register bank with one byte-masked write port and two read ports. State
// changes on the falling edge to match the processor's register convention.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_R0  = 1'b1,
    parameter bit REG_READ = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_2r1w_if.slave bus
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en;

    // Next-state of the bank: merge enabled byte lanes into the addressed entry.
    always_comb begin
        mem_d = mem_q;
        wr_en = bus.we && !(ZERO_R0 && (bus.waddr == '0));
        if (wr_en) begin
            for (int i = 0; i < WIDTH / 8; i++) begin
                mem_d[bus.waddr][8*i +: 8] = lane_merge(mem_q[bus.waddr][8*i +: 8],
                                                        bus.wdata[8*i +: 8], bus.wbe[i]);
            end
        end
    end

    // Bank storage; reset wins over a write in the same cycle.
    // NOTE: the bank itself is reset because a cleared register file is visible architectural state.
    always_ff @(negedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_rdport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
        .ZERO_R0(ZERO_R0), .REG_READ(REG_READ), .BYPASS(BYPASS)
    ) u_rd_a (
        .clk(clk), .rst(rst), .raddr(bus.raddr_a),
        .we(bus.we), .waddr(bus.waddr), .wdata(bus.wdata), .wbe(bus.wbe),
        .mem(mem_q), .rdata(bus.rdata_a)
    );

    regfile_rdport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
        .ZERO_R0(ZERO_R0), .REG_READ(REG_READ), .BYPASS(BYPASS)
    ) u_rd_b (
        .clk(clk), .rst(rst), .raddr(bus.raddr_b),
        .we(bus.we), .waddr(bus.waddr), .wdata(bus.wdata), .wbe(bus.wbe),
        .mem(mem_q), .rdata(bus.rdata_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w. Three instances share one stimulus stream:
//   u0: ZERO_R0=1 REG_READ=0 BYPASS=1 (defaults)
//   u1: ZERO_R0=0 REG_READ=0 BYPASS=0
//   u2: ZERO_R0=1 REG_READ=1 BYPASS=1
// Inputs change 1 ns after each falling (active) edge; expected read data is
// queued then and compared by the monitor at the following rising edge.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = 4'hF;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    regfile_2r1w_if #(.WIDTH(32), .DEPTH(32)) if0 ();
    regfile_2r1w_if #(.WIDTH(32), .DEPTH(32)) if1 ();
    regfile_2r1w_if #(.WIDTH(32), .DEPTH(32)) if2 ();

    assign if0.we = we;  assign if0.waddr = waddr;  assign if0.wdata = wdata;  assign if0.wbe = wbe;
    assign if0.raddr_a = raddr_a;  assign if0.raddr_b = raddr_b;
    assign if1.we = we;  assign if1.waddr = waddr;  assign if1.wdata = wdata;  assign if1.wbe = wbe;
    assign if1.raddr_a = raddr_a;  assign if1.raddr_b = raddr_b;
    assign if2.we = we;  assign if2.waddr = waddr;  assign if2.wdata = wdata;  assign if2.wbe = wbe;
    assign if2.raddr_a = raddr_a;  assign if2.raddr_b = raddr_b;

    regfile_2r1w #(.ZERO_R0(1'b1), .REG_READ(1'b0), .BYPASS(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    regfile_2r1w #(.ZERO_R0(1'b0), .REG_READ(1'b0), .BYPASS(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    regfile_2r1w #(.ZERO_R0(1'b1), .REG_READ(1'b1), .BYPASS(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int dut, input int port);
        case (dut)
            0:       return (port == 0) ? if0.rdata_a : if0.rdata_b;
            1:       return (port == 0) ? if1.rdata_a : if1.rdata_b;
            default: return (port == 0) ? if2.rdata_a : if2.rdata_b;
        endcase
    endfunction

    task automatic expect_rd(input int dut, input int port, input logic [31:0] v, input string name);
        exp_t e;
        e.dut  = dut;
        e.port = port;
        e.exp  = v;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: drains every queued expectation at the rising edge.
    always @(posedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] got;
            e   = sb_q.pop_front();
            got = actual(e.dut, e.port);
            n_compared++;
            if (got !== e.exp) begin
                n_mismatched++;
                $display("FAIL %s: u%0d rdata_%s got %h expected %h",
                         e.name, e.dut, (e.port == 0) ? "a" : "b", got, e.exp);
            end
        end
    end

    // Advance to 1 ns after the next active (falling) edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Two reset edges.
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b1;

        // A: first write after reset, read address 5.
        cyc(); rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wbe = 4'hF; raddr_a = 5'd5;
        expect_rd(0, 0, 32'hDEADBEEF, "bypass_first_write");
        expect_rd(1, 0, 32'h0,        "reset_state_comb");
        expect_rd(2, 0, 32'h0,        "reset_state_reg");
        // B: reset cycle; combinational view is still the old contents.
        cyc(); rst = 1'b1; we = 1'b0;
        expect_rd(0, 0, 32'hDEADBEEF, "pre_reset_view");
        expect_rd(1, 0, 32'hDEADBEEF, "pre_reset_view");
        expect_rd(2, 0, 32'hDEADBEEF, "reg_capture_bypass");
        // C: bank cleared.
        cyc(); rst = 1'b0;
        expect_rd(0, 0, 32'h0, "reset_clears");
        expect_rd(1, 0, 32'h0, "reset_clears");
        expect_rd(2, 0, 32'h0, "reset_clears_reg");

        // D/E/F: byte masking.
        cyc(); we = 1'b1; waddr = 5'd3; wdata = 32'h11223344; wbe = 4'hF; raddr_a = 5'd3; raddr_b = 5'd3;
        expect_rd(1, 1, 32'h0, "nobypass_old");
        cyc(); wdata = 32'hAABBCCDD; wbe = 4'b0101;
        expect_rd(0, 0, 32'h11BB33DD, "bypass_merge");
        expect_rd(1, 0, 32'h11223344, "nobypass_stored");
        expect_rd(2, 0, 32'h11223344, "reg_full_write");
        cyc(); we = 1'b0; wbe = 4'hF;
        expect_rd(0, 0, 32'h11BB33DD, "byte_mask");
        expect_rd(0, 1, 32'h11BB33DD, "byte_mask");
        expect_rd(1, 0, 32'h11BB33DD, "byte_mask");
        expect_rd(2, 1, 32'h11BB33DD, "byte_mask_reg");

        // G/H: write with no lanes enabled is a no-op.
        cyc(); we = 1'b1; waddr = 5'd3; wdata = 32'h0; wbe = 4'h0;
        expect_rd(0, 0, 32'h11BB33DD, "wbe0_bypass");
        cyc(); we = 1'b0; wbe = 4'hF;
        expect_rd(1, 0, 32'h11BB33DD, "wbe0_noop");

        // I/J: entry 0.
        cyc(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr_a = 5'd0; raddr_b = 5'd0;
        expect_rd(0, 0, 32'h0, "zero_bypass");
        expect_rd(0, 1, 32'h0, "zero_bypass");
        expect_rd(1, 0, 32'h0, "r0_nobypass_old");
        cyc(); we = 1'b0;
        expect_rd(0, 0, 32'h0,        "zero_r0");
        expect_rd(0, 1, 32'h0,        "zero_r0");
        expect_rd(1, 0, 32'hFFFFFFFF, "r0_ordinary");
        expect_rd(1, 1, 32'hFFFFFFFF, "r0_ordinary");
        expect_rd(2, 0, 32'h0,        "zero_r0_reg");

        // K/L/M: bypass against a stored value.
        cyc(); we = 1'b1; waddr = 5'd7; wdata = 32'h1; raddr_a = 5'd7;
        cyc(); wdata = 32'h2;
        expect_rd(0, 0, 32'h2, "bypass_new");
        expect_rd(1, 0, 32'h1, "nobypass_before_edge");
        cyc(); we = 1'b0;
        expect_rd(0, 0, 32'h2, "after_edge");
        expect_rd(1, 0, 32'h2, "nobypass_after_edge");

        // N..R: registered-read latency and reset of the read register.
        cyc(); we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE0000;
        cyc(); we = 1'b0; raddr_b = 5'd9;
        expect_rd(2, 1, 32'h0,        "reg_latency_old");
        expect_rd(0, 1, 32'hCAFE0000, "comb_immediate");
        cyc();
        expect_rd(2, 1, 32'hCAFE0000, "reg_latency_new");
        cyc(); rst = 1'b1;
        expect_rd(2, 1, 32'hCAFE0000, "reg_before_reset");
        cyc(); rst = 1'b0;
        expect_rd(2, 1, 32'h0, "reg_reset");
        expect_rd(0, 1, 32'h0, "bank_reset");

        // S..V: reset beats write, then dual read of one address.
        cyc(); rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h12345678; raddr_a = 5'd4; raddr_b = 5'd4;
        cyc(); rst = 1'b0; we = 1'b0;
        expect_rd(0, 0, 32'h0, "reset_beats_write");
        expect_rd(1, 0, 32'h0, "reset_beats_write");
        expect_rd(2, 0, 32'h0, "reset_beats_write_reg");
        cyc(); we = 1'b1; waddr = 5'd4; wdata = 32'h5A5A5A5A;
        cyc(); we = 1'b0;
        for (int d = 0; d < 3; d++) begin
            expect_rd(d, 0, 32'h5A5A5A5A, "dual_read");
            expect_rd(d, 1, 32'h5A5A5A5A, "dual_read");
        end

        // Let the monitor drain; anything left over is a missed comparison.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sb_q.size() > 0) begin
            n_compared   += sb_q.size();
            n_mismatched += sb_q.size();
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
